dual_slope_ctrl: RTL and testbench

// Sequencer for the dual-slope ADC. Drives the integrator analog switches and the control

---
 rtl/dual_slope_pkg.sv | 30 +++
 rtl/dual_slope_sync_ff.sv | 24 ++
 rtl/dual_slope_ctrl.sv | 173 +++++++++++++++++
 tb/tb_dual_slope_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/dual_slope_pkg.sv
// Shared types and constants for the dual-slope ADC sequencer.
package dual_slope_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        AZ    = 3'd1,
        INTEG = 3'd2,
        DEINT = 3'd3,
        LATCH = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam int FULL_SCALE = 1000;

    // Switch bundle ordering: {sw_az, sw_vin, sw_vref}; at most one bit set per state.
    function automatic logic [2:0] switch_decode(input state_t st);
        logic [2:0] sw;
        case (st)
            IDLE:    sw = 3'b100;
            AZ:      sw = 3'b100;
            INTEG:   sw = 3'b010;
            DEINT:   sw = 3'b001;
            LATCH:   sw = 3'b000;
            DONE:    sw = 3'b000;
            default: sw = 3'b100;
        endcase
        return sw;
    endfunction

endpackage

// File: rtl/dual_slope_sync_ff.sv
// Reset-to-zero multi-stage synchronizer for the asynchronous comparator input.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_s,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] pipe_r;

    // Shift the asynchronous input through the synchronizer chain.
    always_ff @(posedge clk or posedge rst_s) begin
        if (rst_s) begin
            pipe_r <= {STAGES{1'b0}};
        end else begin
            pipe_r <= {pipe_r[STAGES-2:0], d};
        end
    end

    assign q = pipe_r[STAGES-1];

endmodule

// File: rtl/dual_slope_ctrl.sv
// Dual-slope ADC sequencer: auto-zero, fixed integrate, de-integrate until the comparator
// trips, then load the display. All outputs come straight from flops.
module dual_slope_ctrl
    import dual_slope_pkg::*;
#(
    parameter int AZ_CYCLES   = 100,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_s,
    input  logic start,
    input  logic comp_in,
    input  logic cnt_max,
    output logic cnt_enb,
    output logic cnt_rst,
    output logic cnt_ld,
    output logic sw_az,
    output logic sw_vin,
    output logic sw_vref,
    output logic busy,
    output logic done,
    output logic ovr
);

    localparam int TW = (AZ_CYCLES > 1) ? $clog2(AZ_CYCLES) : 1;
    localparam logic [TW-1:0] AZ_LAST = TW'(AZ_CYCLES - 1);
    localparam logic [TW-1:0] AZ_PRE  = TW'(AZ_CYCLES - 2);

    state_t        state_r;
    state_t        state_nx_s;
    logic [TW-1:0] timer_r;
    logic [TW-1:0] timer_nx_s;
    logic          start_q_r;
    logic          start_edge_s;
    logic          comp_sync_s;

    logic          cnt_enb_r;
    logic          cnt_rst_r;
    logic          cnt_ld_r;
    logic          sw_az_r;
    logic          sw_vin_r;
    logic          sw_vref_r;
    logic          busy_r;
    logic          done_r;
    logic          ovr_r;

    logic          cnt_rst_nx_s;
    logic          ovr_nx_s;
    logic [2:0]    sw_nx_s;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_comp_sync (
        .clk   (clk),
        .rst_s (rst_s),
        .d     (comp_in),
        .q     (comp_sync_s)
    );

    assign start_edge_s = start & ~start_q_r;

    // Next-state, AZ timer and pulse decisions.
    always_comb begin
        state_nx_s   = state_r;
        timer_nx_s   = timer_r;
        cnt_rst_nx_s = 1'b0;
        ovr_nx_s     = ovr_r;
        case (state_r)
            IDLE: begin
                timer_nx_s = {TW{1'b0}};
                if (start_edge_s) begin
                    state_nx_s   = AZ;
                    cnt_rst_nx_s = 1'b1;
                    ovr_nx_s     = 1'b0;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            AZ: begin
                if (timer_r == AZ_LAST) begin
                    state_nx_s = INTEG;
                    timer_nx_s = {TW{1'b0}};
                end else begin
                    timer_nx_s = timer_r + {{(TW-1){1'b0}}, 1'b1};
                    // Second clear lands in the final AZ cycle so INTEG starts from 000.
                    if (timer_r == AZ_PRE) begin
                        cnt_rst_nx_s = 1'b1;
                    end else begin
                        cnt_rst_nx_s = 1'b0;
                    end
                end
            end
            INTEG: begin
                if (cnt_max) begin
                    state_nx_s = DEINT;
                end else begin
                    state_nx_s = INTEG;
                end
            end
            DEINT: begin
                // Overrange takes priority over a simultaneous comparator trip.
                if (cnt_max) begin
                    state_nx_s = IDLE;
                    ovr_nx_s   = 1'b1;
                end else if (!comp_sync_s) begin
                    state_nx_s = LATCH;
                end else begin
                    state_nx_s = DEINT;
                end
            end
            LATCH: begin
                state_nx_s = DONE;
            end
            DONE: begin
                state_nx_s = IDLE;
            end
            default: begin
                state_nx_s = IDLE;
                timer_nx_s = {TW{1'b0}};
            end
        endcase
        sw_nx_s = switch_decode(state_nx_s);
    end

    // State, timer and start-history registers.
    always_ff @(posedge clk or posedge rst_s) begin
        if (rst_s) begin
            state_r   <= IDLE;
            timer_r   <= {TW{1'b0}};
            start_q_r <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            timer_r   <= timer_nx_s;
            start_q_r <= start;
        end
    end

    // Output flops, decoded from the upcoming state so they align with it.
    always_ff @(posedge clk or posedge rst_s) begin
        if (rst_s) begin
            cnt_enb_r <= 1'b0;
            cnt_rst_r <= 1'b0;
            cnt_ld_r  <= 1'b0;
            sw_az_r   <= 1'b1;
            sw_vin_r  <= 1'b0;
            sw_vref_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            ovr_r     <= 1'b0;
        end else begin
            cnt_enb_r <= (state_nx_s == INTEG) || (state_nx_s == DEINT);
            cnt_rst_r <= cnt_rst_nx_s;
            cnt_ld_r  <= (state_nx_s == LATCH);
            sw_az_r   <= sw_nx_s[2];
            sw_vin_r  <= sw_nx_s[1];
            sw_vref_r <= sw_nx_s[0];
            busy_r    <= (state_nx_s != IDLE);
            done_r    <= (state_nx_s == DONE);
            ovr_r     <= ovr_nx_s;
        end
    end

    assign cnt_enb = cnt_enb_r;
    assign cnt_rst = cnt_rst_r;
    assign cnt_ld  = cnt_ld_r;
    assign sw_az   = sw_az_r;
    assign sw_vin  = sw_vin_r;
    assign sw_vref = sw_vref_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign ovr     = ovr_r;

endmodule

// File: tb/tb_dual_slope_ctrl.sv
// Randomized bench for dual_slope_ctrl with a behavioural 000..999 counter/display and a
// timeline-based expectation of each conversion.
module tb_dual_slope_ctrl;

    localparam int AZ_N   = 4;
    localparam int SYNC_N = 2;
    localparam int FS     = 1000;

    logic clk = 1'b0;
    logic rst_s;
    logic start;
    logic comp_in;
    logic cnt_max;
    logic cnt_enb, cnt_rst, cnt_ld, sw_az, sw_vin, sw_vref, busy, done, ovr;

    int count_m  = 0;
    int disp_m   = 0;
    int exp_disp = 0;
    int checks   = 0;
    int failures = 0;
    int excl_err = 0;

    dual_slope_ctrl #(
        .AZ_CYCLES   (AZ_N),
        .SYNC_STAGES (SYNC_N)
    ) dut (
        .clk     (clk),
        .rst_s   (rst_s),
        .start   (start),
        .comp_in (comp_in),
        .cnt_max (cnt_max),
        .cnt_enb (cnt_enb),
        .cnt_rst (cnt_rst),
        .cnt_ld  (cnt_ld),
        .sw_az   (sw_az),
        .sw_vin  (sw_vin),
        .sw_vref (sw_vref),
        .busy    (busy),
        .done    (done),
        .ovr     (ovr)
    );

    always #5 clk = ~clk;

    // Behavioural BCD counter (modelled as an integer 0..999) with async clear.
    always @(posedge clk or posedge cnt_rst) begin
        if (cnt_rst) count_m <= 0;
        else if (cnt_enb) count_m <= (count_m == FS - 1) ? 0 : count_m + 1;
    end

    // Display register.
    always @(posedge clk) begin
        if (cnt_ld) disp_m <= count_m;
    end

    assign cnt_max = (count_m == FS - 1);

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // One conversion: comp_in is first sampled low n edges after DEINT entry.
    task automatic run_conv(input int n, input bit hold, input bit poke);
        int  drop_t, len, vin, az, rst_c, ld_c, ld_t, done_c, done_t, busy_c, idle_busy;
        bit  ovr_exp;
        ovr_exp = (n + SYNC_N >= FS);
        drop_t  = AZ_N + FS + n - 1;
        len     = ovr_exp ? AZ_N + 2 * FS : AZ_N + FS + n + SYNC_N + 2;
        vin = 0; az = 0; rst_c = 0; ld_c = 0; done_c = 0; busy_c = 0;
        ld_t = -1; done_t = -1;
        @(negedge clk);
        comp_in = 1'b1;
        start   = 1'b1;
        for (int t = 0; t < len + 6; t++) begin
            @(negedge clk);
            if (t == 0) begin
                chk("busy_first", busy, 1);
                chk("ovr_clr", ovr, 0);
            end
            vin    += int'(sw_vin);
            az     += int'(sw_az & busy);
            rst_c  += int'(cnt_rst);
            ld_c   += int'(cnt_ld);
            done_c += int'(done);
            busy_c += int'(busy);
            if (cnt_ld) ld_t = t;
            if (done) done_t = t;
            if (int'(sw_az) + int'(sw_vin) + int'(sw_vref) > 1) excl_err++;
            if (t == 0 && !hold) start = 1'b0;
            if (poke && t == AZ_N + FS + 10) start = 1'b0;
            if (poke && t == AZ_N + FS + 12) start = 1'b1;
            if (poke && !hold && t == AZ_N + FS + 14) start = 1'b0;
            if (t == drop_t) comp_in = 1'b0;
        end
        if (!ovr_exp) exp_disp = n + SYNC_N;
        chk("integ_len", vin, FS);
        chk("az_len", az, AZ_N);
        chk("cnt_rst_pulses", rst_c, 2);
        chk("busy_len", busy_c, len);
        chk("ld_count", ld_c, ovr_exp ? 0 : 1);
        chk("ld_time", ld_t, ovr_exp ? -1 : AZ_N + FS + n + SYNC_N);
        chk("done_count", done_c, ovr_exp ? 0 : 1);
        chk("done_time", done_t, ovr_exp ? -1 : AZ_N + FS + n + SYNC_N + 1);
        chk("ovr", ovr, int'(ovr_exp));
        chk("display", disp_m, exp_disp);
        if (hold) begin
            idle_busy = 0;
            for (int t = 0; t < 20; t++) begin
                @(negedge clk);
                idle_busy += int'(busy);
            end
            chk("no_restart", idle_busy, 0);
            start = 1'b0;
        end
    endtask

    task automatic mid_reset();
        int stray;
        @(negedge clk);
        comp_in = 1'b1;
        start   = 1'b1;
        for (int t = 0; t < 500; t++) begin
            @(negedge clk);
            if (t == 0) start = 1'b0;
        end
        chk("midinteg_vin", sw_vin, 1);
        rst_s = 1'b1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_sw_az", sw_az, 1);
        chk("rst_sw_vin", sw_vin, 0);
        chk("rst_sw_vref", sw_vref, 0);
        chk("rst_cnt_enb", cnt_enb, 0);
        chk("rst_cnt_rst", cnt_rst, 0);
        chk("rst_ld_done", int'(cnt_ld) + int'(done), 0);
        @(negedge clk);
        rst_s = 1'b0;
        stray = 0;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            stray += int'(cnt_ld) + int'(done) + int'(busy);
        end
        chk("post_rst_quiet", stray, 0);
        chk("post_rst_display", disp_m, exp_disp);
    endtask

    initial begin
        int n;
        rst_s   = 1'b1;
        start   = 1'b0;
        comp_in = 1'b1;
        repeat (3) @(negedge clk);
        rst_s = 1'b0;
        repeat (10) @(negedge clk);
        chk("idle_sw_az", sw_az, 1);
        chk("idle_busy", busy, 0);
        chk("idle_cnt_enb", cnt_enb, 0);
        chk("idle_cnt_ld", cnt_ld, 0);
        chk("idle_done", done, 0);
        chk("idle_ovr", ovr, 0);
        chk("idle_switches", int'(sw_vin) + int'(sw_vref), 0);

        run_conv(300, 1'b0, 1'b0);
        run_conv(0, 1'b0, 1'b0);
        run_conv(5000, 1'b0, 1'b0);
        run_conv(997, 1'b1, 1'b0);
        run_conv(998, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            n = int'($urandom_range(0, 996));
            run_conv(n, i[0], 1'b0);
        end
        run_conv(int'($urandom_range(20, 900)), 1'b0, 1'b1);
        run_conv(int'($urandom_range(20, 900)), 1'b1, 1'b1);
        mid_reset();
        run_conv(int'($urandom_range(0, 996)), 1'b0, 1'b0);
        chk("switch_exclusive", excl_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
